// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and helpers for the accelerator offload responder.
package acc_pkg;

  localparam int unsigned InstrWidth = 32;
  localparam int unsigned RegWidth   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } acc_rsp_state_e;

  // Writeback class 2'b00 marks a fire-and-forget instruction with no response.
  function automatic logic needs_resp(input logic [1:0] writeback);
    return writeback != 2'b00;
  endfunction

endpackage

// File: rtl/acc_req_fifo.sv
// rtl/acc_req_fifo.sv - synchronous request FIFO with full/empty/count status.
module acc_req_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  // A full FIFO refuses pushes even when the head is popped in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (PtrW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (PtrW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/acc_offload_responder.sv
// rtl/acc_offload_responder.sv - offload endpoint: buffers requests, issues them one at a time, returns responses in order.
// Optional datapath watchdog enabled by defining ACC_RESP_TIMEOUT_EN.
module acc_offload_responder
  import acc_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumRs         = 3,
  parameter int unsigned IdWidth       = 5,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       q_valid_i,
  output logic                       q_ready_o,
  input  logic [InstrWidth-1:0]      q_instr_i,
  input  logic [NumRs*DataWidth-1:0] q_rs_i,
  input  logic [RegWidth-1:0]        q_rd_i,
  input  logic [IdWidth-1:0]         q_id_i,
  input  logic [1:0]                 q_writeback_i,
  output logic                       ex_valid_o,
  input  logic                       ex_ready_i,
  output logic [InstrWidth-1:0]      ex_instr_o,
  output logic [NumRs*DataWidth-1:0] ex_rs_o,
  input  logic                       ex_done_i,
  input  logic [DataWidth-1:0]       ex_result_i,
  input  logic                       ex_error_i,
  output logic                       ex_kill_o,
  output logic                       p_valid_o,
  input  logic                       p_ready_i,
  output logic [DataWidth-1:0]       p_data_o,
  output logic [RegWidth-1:0]        p_rd_o,
  output logic [IdWidth-1:0]         p_id_o,
  output logic                       p_error_o,
  output logic                       busy_o
);

  localparam int unsigned RsWidth = NumRs * DataWidth;

  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0 || TimeoutCycles == 0) begin : g_param_check
    $error("acc_offload_responder: FifoDepth must be a power of two >= 2 and TimeoutCycles > 0");
  end

  typedef struct packed {
    logic [InstrWidth-1:0] instr;
    logic [RsWidth-1:0]    rs;
    logic [RegWidth-1:0]   rd;
    logic [IdWidth-1:0]    id;
    logic [1:0]            writeback;
  } acc_offl_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [RegWidth-1:0]  rd;
    logic [IdWidth-1:0]   id;
    logic                 error;
  } acc_offl_rsp_t;

  acc_rsp_state_e state_q, state_d;
  acc_offl_req_t  req_q, req_d;
  acc_offl_rsp_t  rsp_q, rsp_d;
  acc_offl_req_t  fifo_wdata, fifo_head;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FifoDepth):0] fifo_count;
  logic           done_capture;

  assign fifo_wdata = '{instr: q_instr_i, rs: q_rs_i, rd: q_rd_i, id: q_id_i, writeback: q_writeback_i};
  assign q_ready_o  = ~fifo_full;
  assign fifo_push  = q_valid_i & q_ready_o;

  acc_req_fifo #(
    .Width ($bits(acc_offl_req_t)),
    .Depth (FifoDepth)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef ACC_RESP_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            kill_q, kill_d;
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rsp_d        = rsp_q;
    fifo_pop     = 1'b0;
    ex_valid_o   = 1'b0;
    p_valid_o    = 1'b0;
    done_capture = 1'b0;
`ifdef ACC_RESP_TIMEOUT_EN
    cnt_d        = cnt_q;
    kill_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          req_d    = fifo_head;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        ex_valid_o = 1'b1;
        if (ex_ready_i) begin
          if (ex_done_i) begin
            done_capture = 1'b1;
          end else begin
            state_d = WAIT;
`ifdef ACC_RESP_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      WAIT: begin
        if (ex_done_i) begin
          done_capture = 1'b1;
`ifdef ACC_RESP_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          // Watchdog expiry: abort the datapath and report an error result.
          kill_d  = 1'b1;
          rsp_d   = '{data: '0, rd: req_q.rd, id: req_q.id, error: 1'b1};
          state_d = needs_resp(req_q.writeback) ? RESP : IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      RESP: begin
        p_valid_o = 1'b1;
        if (p_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done_capture) begin
      rsp_d   = '{data: ex_result_i, rd: req_q.rd, id: req_q.id, error: ex_error_i};
      state_d = needs_resp(req_q.writeback) ? RESP : IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  end

`ifdef ACC_RESP_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      kill_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      kill_q <= kill_d;
    end
  end
  assign ex_kill_o = kill_q;
`else
  assign ex_kill_o = 1'b0;
`endif

  assign ex_instr_o = req_q.instr;
  assign ex_rs_o    = req_q.rs;
  assign p_data_o   = rsp_q.data;
  assign p_rd_o     = rsp_q.rd;
  assign p_id_o     = rsp_q.id;
  assign p_error_o  = rsp_q.error;
  assign busy_o     = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_acc_offload_responder.sv
// tb/tb_acc_offload_responder.sv - directed, table-driven bench for acc_offload_responder.
module tb_acc_offload_responder;

  localparam int DW = 32;
  localparam int NR = 3;
  localparam int IW = 5;
`ifdef ACC_RESP_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           q_valid = 1'b0;
  logic           q_ready_o;
  logic [31:0]    q_instr = '0;
  logic [NR*DW-1:0] q_rs = '0;
  logic [4:0]     q_rd = '0;
  logic [IW-1:0]  q_id = '0;
  logic [1:0]     q_wb = '0;
  logic           ex_valid_o;
  logic           ex_ready = 1'b0;
  logic [31:0]    ex_instr_o;
  logic [NR*DW-1:0] ex_rs_o;
  logic           ex_done = 1'b0;
  logic [DW-1:0]  ex_result = '0;
  logic           ex_error = 1'b0;
  logic           ex_kill_o;
  logic           p_valid_o;
  logic           p_ready = 1'b0;
  logic [DW-1:0]  p_data_o;
  logic [4:0]     p_rd_o;
  logic [IW-1:0]  p_id_o;
  logic           p_error_o;
  logic           busy_o;

  acc_offload_responder #(
    .DataWidth(DW), .NumRs(NR), .IdWidth(IW), .FifoDepth(4), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .q_valid_i(q_valid), .q_ready_o(q_ready_o), .q_instr_i(q_instr), .q_rs_i(q_rs),
    .q_rd_i(q_rd), .q_id_i(q_id), .q_writeback_i(q_wb),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready), .ex_instr_o(ex_instr_o), .ex_rs_o(ex_rs_o),
    .ex_done_i(ex_done), .ex_result_i(ex_result), .ex_error_i(ex_error), .ex_kill_o(ex_kill_o),
    .p_valid_o(p_valid_o), .p_ready_i(p_ready), .p_data_o(p_data_o), .p_rd_o(p_rd_o),
    .p_id_o(p_id_o), .p_error_o(p_error_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [4:0]    rd;
    logic [1:0]    wb;
    logic [31:0]   instr;
    logic [31:0]   result;
    logic          err;
    int            delay;
    logic          exp_pvalid;
    logic [31:0]   exp_data;
    logic          exp_error;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] rs_of(input logic [31:0] instr);
    return {instr ^ 32'h3333_3333, instr ^ 32'h2222_2222, instr ^ 32'h1111_1111};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [IW-1:0] id, input logic [4:0] rd, input logic [1:0] wb,
                      input logic [31:0] instr);
    int k = 0;
    q_valid = 1'b1; q_id = id; q_rd = rd; q_wb = wb; q_instr = instr; q_rs = rs_of(instr);
    while (!q_ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("push_ready", q_ready_o, 1);
    @(posedge clk);
    #1 q_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve(input vec_t v, input bit expect_idle);
    int k = 0;
    while (!ex_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ex_valid", ex_valid_o, 1);
    check("ex_instr", ex_instr_o, v.instr);
    check("ex_rs", ex_rs_o, rs_of(v.instr));
    ex_ready = 1'b1;
    if (v.delay == 0) begin
      ex_done = 1'b1; ex_result = v.result; ex_error = v.err;
    end
    @(posedge clk);
    #1 ex_ready = 1'b0; ex_done = 1'b0;
    @(negedge clk);
    if (v.delay > 0) begin
      repeat (v.delay - 1) @(negedge clk);
      check("ex_valid_in_wait", ex_valid_o, 0);
      check("p_valid_in_wait", p_valid_o, 0);
      ex_done = 1'b1; ex_result = v.result; ex_error = v.err;
      @(posedge clk);
      #1 ex_done = 1'b0;
      @(negedge clk);
    end
    check("p_valid", p_valid_o, v.exp_pvalid);
    if (v.exp_pvalid) begin
      check("p_data", p_data_o, v.exp_data);
      check("p_rd", p_rd_o, v.rd);
      check("p_id", p_id_o, v.id);
      check("p_error", p_error_o, v.exp_error);
      repeat (2) @(negedge clk);
      check("p_valid_held", p_valid_o, 1);
      check("p_data_held", p_data_o, v.exp_data);
      p_ready = 1'b1;
      @(posedge clk);
      #1 p_ready = 1'b0;
      @(negedge clk);
      check("p_valid_drop", p_valid_o, 0);
    end else if (expect_idle) begin
      check("busy_after_retire", busy_o, 0);
    end
  endtask

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int seen;
    int kills;
    int first_kill;

    vecs[0] = '{5'd3,  5'd5,  2'b01, 32'h0000_1003, 32'hDEAD_BEEF, 1'b0, 2, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{5'd7,  5'd9,  2'b00, 32'h0000_2007, 32'h1234_5678, 1'b1, 1, 1'b0, 32'h0,         1'b0};
    vecs[2] = '{5'd12, 5'd17, 2'b10, 32'h0000_300C, 32'hCAFE_F00D, 1'b0, 0, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{5'd31, 5'd31, 2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3, 1'b1, 32'h0000_0000, 1'b1};
    vecs[4] = '{5'd0,  5'd0,  2'b00, 32'h0000_5000, 32'h5555_AAAA, 1'b0, 0, 1'b0, 32'h0,         1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_q_ready", q_ready_o, 1);
    check("rst_ex_valid", ex_valid_o, 0);
    check("rst_p_valid", p_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ex_kill", ex_kill_o, 0);
    check("rst_p_data", p_data_o, 0);

    // Single transactions: writeback, silent retire, same-cycle done, error
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].id, vecs[i].rd, vecs[i].wb, vecs[i].instr);
      serve(vecs[i], 1'b1);
    end

    // Backpressure: head moves to issue register, 4 more fill the FIFO
    for (int i = 0; i < 5; i++) push(IW'(i), 5'(i + 1), 2'b01, 32'h100 + i);
    check("full_q_ready", q_ready_o, 0);
    check("full_ex_valid", ex_valid_o, 1);
    check("full_head_instr", ex_instr_o, 32'h100);
    fork
      push(IW'(5), 5'd6, 2'b01, 32'h105);
    join_none
    for (int i = 0; i < 6; i++) begin
      v = '{IW'(i), 5'(i + 1), 2'b01, 32'h100 + i, 32'hA000 + i, 1'b0, 1, 1'b1, 32'hA000 + i, 1'b0};
      serve(v, 1'b0);
    end
    @(negedge clk);
    check("drain_busy", busy_o, 0);

    // Reset while waiting on the datapath with 3 requests buffered
    push(5'd20, 5'd1, 2'b01, 32'h2020);
    while (!ex_valid_o) @(negedge clk);
    ex_ready = 1'b1;
    @(posedge clk);
    #1 ex_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(IW'(21 + i), 5'd2, 2'b01, 32'h2021 + i);
    check("wait_ex_valid", ex_valid_o, 0);
    check("wait_busy", busy_o, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_q_ready", q_ready_o, 1);
    check("mid_rst_ex_valid", ex_valid_o, 0);
    check("mid_rst_p_valid", p_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ex_instr", ex_instr_o, 0);
    ex_done = 1'b1; ex_result = 32'hBAD0_BAD0;
    @(posedge clk);
    #1 ex_done = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (p_valid_o || ex_valid_o || busy_o) seen++;
    end
    check("no_stale_activity", seen, 0);

    // Long datapath wait: watchdog or indefinite hold
    push(5'd9, 5'd4, 2'b01, 32'h0900);
    while (!ex_valid_o) @(negedge clk);
    ex_ready = 1'b1;
    @(posedge clk);
    #1 ex_ready = 1'b0;
    kills = 0;
    first_kill = -1;
`ifdef ACC_RESP_TIMEOUT_EN
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ex_kill_o) begin
        kills++;
        if (first_kill < 0) first_kill = c;
      end
    end
    check("kill_pulses", kills, 1);
    check("kill_cycle", first_kill, 8);
    check("to_p_valid", p_valid_o, 1);
    check("to_p_error", p_error_o, 1);
    check("to_p_data", p_data_o, 0);
    check("to_p_id", p_id_o, 9);
    p_ready = 1'b1;
    @(posedge clk);
    #1 p_ready = 1'b0;
    @(negedge clk);
    check("to_done_busy", busy_o, 0);
`else
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ex_kill_o) kills++;
      if (p_valid_o) seen++;
    end
    check("no_kill", kills, 0);
    check("no_early_p_valid", seen, 0);
    ex_done = 1'b1; ex_result = 32'h0000_0055; ex_error = 1'b0;
    @(posedge clk);
    #1 ex_done = 1'b0;
    @(negedge clk);
    check("late_p_valid", p_valid_o, 1);
    check("late_p_data", p_data_o, 32'h55);
    check("late_p_id", p_id_o, 9);
    p_ready = 1'b1;
    @(posedge clk);
    #1 p_ready = 1'b0;
    @(negedge clk);
    check("late_done_busy", busy_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
